// File: rtl/rob_commit.sv
// Dual-issue reorder buffer with in-order, two-wide commit.
// Also drives the commit side of the speculative location table (newest-mapping enables).
module rob_commit #(
   parameter int DEPTH = 16,
   parameter int TAGW  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            recover,
   input  logic            stall_RNR,
   input  logic            ins1_v,
   input  logic            ins2_v,
   input  logic [4:0]      rd1l,
   input  logic [4:0]      rd2l,
   input  logic            rd1_en,
   input  logic            rd2_en,
   output logic [TAGW-1:0] tag1,
   output logic [TAGW-1:0] tag2,
   output logic            rob_full,
   input  logic            wb1_v,
   input  logic [TAGW-1:0] wb1_tag,
   input  logic            wb2_v,
   input  logic [TAGW-1:0] wb2_tag,
   output logic            com1_v,
   output logic            com2_v,
   output logic [4:0]      rd1l_c,
   output logic [4:0]      rd2l_c,
   output logic            rd1_enc,
   output logic            rd2_enc
);

   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] done;
   logic [DEPTH-1:0] ent_rd_en;
   logic [4:0]       ent_rdl [DEPTH];

   logic [31:0]      lv;
   logic [TAGW-1:0]  ltag [32];

   logic [TAGW-1:0]  head;
   logic [TAGW-1:0]  tail;
   logic [TAGW:0]    count;

   logic [TAGW-1:0]  head_p1;
   logic [TAGW-1:0]  tail_p1;
   logic [1:0]       req;
   logic [TAGW:0]    free_cnt;
   logic             alloc;
   logic [1:0]       alloc_n;
   logic             c1;
   logic             c2;
   logic [1:0]       commit_n;
   logic [4:0]       h_rdl;
   logic [4:0]       n_rdl;
   logic             hit1;
   logic             hit2;
   logic             enc1;
   logic             enc2;

   assign head_p1  = head + TAGW'(1);
   assign tail_p1  = tail + TAGW'(1);
   assign req      = {1'b0, ins1_v} + {1'b0, ins2_v};
   assign free_cnt = (TAGW+1)'(DEPTH) - count;
   assign rob_full = {{(TAGW-1){1'b0}}, req} > free_cnt;
   assign tag1     = tail;
   assign tag2     = ins1_v ? tail_p1 : tail;

   // Commit decision and newest-mapping test, all from registered state plus this cycle's rename.
   always_comb begin
      alloc    = 1'b0;
      alloc_n  = 2'd0;
      c1       = 1'b0;
      c2       = 1'b0;
      commit_n = 2'd0;
      h_rdl    = ent_rdl[head];
      n_rdl    = ent_rdl[head_p1];
      hit1     = 1'b0;
      hit2     = 1'b0;
      enc1     = 1'b0;
      enc2     = 1'b0;

      alloc    = !stall_RNR && !recover && !rob_full;
      alloc_n  = alloc ? req : 2'd0;
      c1       = valid[head] && done[head];
      c2       = c1 && valid[head_p1] && done[head_p1];
      commit_n = {1'b0, c1} + {1'b0, c2};

      // A rename writing the same register this cycle supersedes the retiring mapping.
      hit1 = alloc && ((ins1_v && rd1_en && rd1l == h_rdl) ||
                       (ins2_v && rd2_en && rd2l == h_rdl));
      hit2 = alloc && ((ins1_v && rd1_en && rd1l == n_rdl) ||
                       (ins2_v && rd2_en && rd2l == n_rdl));

      enc2 = c2 && ent_rd_en[head_p1] && lv[n_rdl] && (ltag[n_rdl] == head_p1) && !hit2;
      enc1 = c1 && ent_rd_en[head] && lv[h_rdl] && (ltag[h_rdl] == head) && !hit1 &&
             !(c2 && ent_rd_en[head_p1] && (n_rdl == h_rdl));
   end

   // Later assignments win: commit clears override writeback, allocation overrides lv clears.
   always_ff @(posedge clk) begin
      if (rst || recover) begin
         valid   <= '0;
         done    <= '0;
         lv      <= '0;
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         com1_v  <= 1'b0;
         com2_v  <= 1'b0;
         rd1l_c  <= 5'd0;
         rd2l_c  <= 5'd0;
         rd1_enc <= 1'b0;
         rd2_enc <= 1'b0;
      end else begin
         if (wb1_v && valid[wb1_tag]) done[wb1_tag] <= 1'b1;
         if (wb2_v && valid[wb2_tag]) done[wb2_tag] <= 1'b1;

         if (c1) begin
            valid[head] <= 1'b0;
            done[head]  <= 1'b0;
         end
         if (c2) begin
            valid[head_p1] <= 1'b0;
            done[head_p1]  <= 1'b0;
         end
         if (enc1) lv[h_rdl] <= 1'b0;
         if (enc2) lv[n_rdl] <= 1'b0;

         if (alloc && ins1_v) begin
            valid[tail]     <= 1'b1;
            done[tail]      <= 1'b0;
            ent_rd_en[tail] <= rd1_en;
            ent_rdl[tail]   <= rd1l;
            if (rd1_en) begin
               lv[rd1l]   <= 1'b1;
               ltag[rd1l] <= tail;
            end
         end
         if (alloc && ins2_v) begin
            valid[tag2]     <= 1'b1;
            done[tag2]      <= 1'b0;
            ent_rd_en[tag2] <= rd2_en;
            ent_rdl[tag2]   <= rd2l;
            if (rd2_en) begin
               lv[rd2l]   <= 1'b1;
               ltag[rd2l] <= tag2;
            end
         end

         head  <= head + TAGW'(commit_n);
         tail  <= tail + TAGW'(alloc_n);
         count <= count + (TAGW+1)'(alloc_n) - (TAGW+1)'(commit_n);

         com1_v  <= c1;
         com2_v  <= c2;
         rd1l_c  <= c1 ? h_rdl : 5'd0;
         rd2l_c  <= c2 ? n_rdl : 5'd0;
         rd1_enc <= enc1;
         rd2_enc <= enc2;
      end
   end

endmodule

// File: tb/tb_rob_commit.sv
// Randomized and directed bench for rob_commit against a queue-based reference model.
// The model keeps in-flight instructions as an ordered queue and a per-register newest-writer map.
module tb_rob_commit;

   localparam int DEPTH = 16;
   localparam int TAGW  = 4;

   logic            clk = 1'b0;
   logic            rst, recover, stall_RNR;
   logic            ins1_v, ins2_v, rd1_en, rd2_en;
   logic [4:0]      rd1l, rd2l;
   logic [TAGW-1:0] tag1, tag2;
   logic            rob_full;
   logic            wb1_v, wb2_v;
   logic [TAGW-1:0] wb1_tag, wb2_tag;
   logic            com1_v, com2_v, rd1_enc, rd2_enc;
   logic [4:0]      rd1l_c, rd2l_c;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int tag;
      int rdl;
      bit rd_en;
      bit done;
   } ent_t;

   ent_t q[$];
   bit   m_lv   [32];
   int   m_ltag [32];
   int   m_tail = 0;

   bit   x_com1, x_com2, x_enc1, x_enc2;
   int   x_rd1l, x_rd2l;

   rob_commit #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
      .clk(clk), .rst(rst), .recover(recover), .stall_RNR(stall_RNR),
      .ins1_v(ins1_v), .ins2_v(ins2_v), .rd1l(rd1l), .rd2l(rd2l),
      .rd1_en(rd1_en), .rd2_en(rd2_en), .tag1(tag1), .tag2(tag2), .rob_full(rob_full),
      .wb1_v(wb1_v), .wb1_tag(wb1_tag), .wb2_v(wb2_v), .wb2_tag(wb2_tag),
      .com1_v(com1_v), .com2_v(com2_v), .rd1l_c(rd1l_c), .rd2l_c(rd2l_c),
      .rd1_enc(rd1_enc), .rd2_enc(rd2_enc)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic idle();
      rst = 0; recover = 0; stall_RNR = 0;
      ins1_v = 0; ins2_v = 0; rd1_en = 0; rd2_en = 0; rd1l = 0; rd2l = 0;
      wb1_v = 0; wb2_v = 0; wb1_tag = 0; wb2_tag = 0;
   endtask

   function automatic bit allocHits(input bit alloc, input int r);
      return alloc && ((ins1_v && rd1_en && int'(rd1l) == r) ||
                       (ins2_v && rd2_en && int'(rd2l) == r));
   endfunction

   // One clock: check combinational outputs, advance the model, check registered outputs.
   task automatic applyStimulus();
      int  req, free, r0, r1;
      bit  c1, c2, alloc;
      #1;
      req  = int'(ins1_v) + int'(ins2_v);
      free = DEPTH - q.size();
      checkOutput("rob_full", rob_full, req > free);
      checkOutput("tag1", tag1, m_tail);
      checkOutput("tag2", tag2, ins1_v ? (m_tail + 1) % DEPTH : m_tail);

      x_com1 = 0; x_com2 = 0; x_enc1 = 0; x_enc2 = 0; x_rd1l = 0; x_rd2l = 0;
      if (rst || recover) begin
         q.delete();
         foreach (m_lv[i]) m_lv[i] = 0;
         m_tail = 0;
      end else begin
         c1    = q.size() > 0 && q[0].done;
         c2    = c1 && q.size() > 1 && q[1].done;
         alloc = !stall_RNR && req <= free;
         if (c1) begin
            r0     = q[0].rdl;
            x_rd1l = r0;
            x_enc1 = q[0].rd_en && m_lv[r0] && m_ltag[r0] == q[0].tag && !allocHits(alloc, r0) &&
                     !(c2 && q[1].rd_en && q[1].rdl == r0);
         end
         if (c2) begin
            r1     = q[1].rdl;
            x_rd2l = r1;
            x_enc2 = q[1].rd_en && m_lv[r1] && m_ltag[r1] == q[1].tag && !allocHits(alloc, r1);
         end
         x_com1 = c1;
         x_com2 = c2;
         foreach (q[i])
            if ((wb1_v && q[i].tag == int'(wb1_tag)) || (wb2_v && q[i].tag == int'(wb2_tag)))
               q[i].done = 1;
         if (x_enc1) m_lv[q[0].rdl] = 0;
         if (x_enc2) m_lv[q[1].rdl] = 0;
         if (c1) void'(q.pop_front());
         if (c2) void'(q.pop_front());
         if (alloc && ins1_v) begin
            q.push_back('{tag: m_tail, rdl: int'(rd1l), rd_en: rd1_en, done: 0});
            if (rd1_en) begin m_lv[rd1l] = 1; m_ltag[rd1l] = m_tail; end
            m_tail = (m_tail + 1) % DEPTH;
         end
         if (alloc && ins2_v) begin
            q.push_back('{tag: m_tail, rdl: int'(rd2l), rd_en: rd2_en, done: 0});
            if (rd2_en) begin m_lv[rd2l] = 1; m_ltag[rd2l] = m_tail; end
            m_tail = (m_tail + 1) % DEPTH;
         end
      end

      @(posedge clk);
      #1;
      checkOutput("com1_v", com1_v, x_com1);
      checkOutput("com2_v", com2_v, x_com2);
      checkOutput("rd1l_c", rd1l_c, x_rd1l);
      checkOutput("rd2l_c", rd2l_c, x_rd2l);
      checkOutput("rd1_enc", rd1_enc, x_enc1);
      checkOutput("rd2_enc", rd2_enc, x_enc2);
   endtask

   task automatic doReset();
      idle(); rst = 1; applyStimulus(); idle();
   endtask

   task automatic alloc2(input int a, input bit ea, input int b, input bit eb);
      idle();
      ins1_v = 1; rd1l = 5'(a); rd1_en = ea;
      ins2_v = 1; rd2l = 5'(b); rd2_en = eb;
      applyStimulus(); idle();
   endtask

   task automatic alloc1(input int a);
      idle(); ins1_v = 1; rd1l = 5'(a); rd1_en = 1; applyStimulus(); idle();
   endtask

   task automatic wb(input bit v1, input int t1, input bit v2, input int t2);
      idle();
      wb1_v = v1; wb1_tag = TAGW'(t1); wb2_v = v2; wb2_tag = TAGW'(t2);
      applyStimulus(); idle();
   endtask

   initial begin
      idle();
      @(posedge clk); #1;

      // Reset state; tags visible with slot 1 requesting while stalled.
      doReset();
      ins1_v = 1; ins2_v = 1; stall_RNR = 1;
      #1;
      checkOutput("reset_tag1", tag1, 0);
      checkOutput("reset_tag2", tag2, 1);
      checkOutput("reset_full", rob_full, 0);
      checkOutput("reset_com1", com1_v, 0);
      checkOutput("reset_enc1", rd1_enc, 0);
      applyStimulus(); idle();

      // Basic dual alloc, dual writeback, dual commit.
      alloc2(3, 1, 5, 1);
      wb(1, 0, 1, 1);
      idle(); applyStimulus();
      checkOutput("basic_com2", com2_v, 1);
      checkOutput("basic_rd2l", rd2l_c, 5);
      checkOutput("basic_enc1", rd1_enc, 1);

      // Two writers of r7: only the younger keeps the mapping.
      alloc1(7); alloc1(7);
      wb(1, 2, 1, 3);
      idle(); applyStimulus();
      checkOutput("r7_enc1", rd1_enc, 0);
      checkOutput("r7_enc2", rd2_enc, 1);

      // Fill to full, rejected request, then wrap after two commits.
      doReset();
      for (int i = 0; i < 8; i++) alloc2(i, 1, i + 10, 1);
      idle(); ins1_v = 1; ins2_v = 1; rd1_en = 1; rd1l = 20;
      applyStimulus();
      checkOutput("full_seen", rob_full, 1);
      wb(1, 0, 1, 1);
      idle(); applyStimulus();
      alloc2(21, 1, 22, 1);
      for (int i = 0; i < 10; i++) wb(1, (2 + 2 * i) % DEPTH, 1, (3 + 2 * i) % DEPTH);
      for (int i = 0; i < 3; i++) begin idle(); applyStimulus(); end

      // Commit of r9 while rename writes r9; new mapping must survive.
      doReset();
      alloc1(9);
      wb(1, 0, 0, 0);
      alloc1(9);
      checkOutput("r9_enc1", rd1_enc, 0);
      wb(1, 1, 0, 0);
      idle(); applyStimulus();
      checkOutput("r9_new_enc", rd1_enc, 1);

      // Only head done, then only head+1 done.
      doReset();
      alloc2(1, 1, 2, 1);
      wb(1, 0, 0, 0);
      idle(); applyStimulus();
      checkOutput("head_only_com2", com2_v, 0);
      alloc2(4, 1, 6, 0);
      wb(1, 3, 0, 0);
      idle(); applyStimulus();
      checkOutput("next_only_com1", com1_v, 0);

      // Recover with six in flight; stale writeback ignored.
      doReset();
      for (int i = 0; i < 3; i++) alloc2(i + 1, 1, i + 4, 1);
      wb(1, 0, 1, 1);
      idle(); recover = 1; applyStimulus(); idle();
      wb(1, 2, 1, 0);
      idle(); applyStimulus();
      alloc2(8, 1, 9, 1);

      // Random traffic with occasional recover and reset.
      doReset();
      for (int n = 0; n < 3000; n++) begin
         idle();
         ins1_v    = ($urandom_range(0, 9) < 7);
         ins2_v    = ($urandom_range(0, 9) < 6);
         rd1l      = 5'($urandom_range(0, 7));
         rd2l      = 5'($urandom_range(0, 7));
         rd1_en    = ($urandom_range(0, 3) != 0);
         rd2_en    = ($urandom_range(0, 3) != 0);
         stall_RNR = ($urandom_range(0, 9) == 0);
         wb1_v     = ($urandom_range(0, 9) < 7);
         wb2_v     = ($urandom_range(0, 9) < 5);
         wb1_tag   = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                     TAGW'(q[$urandom_range(0, q.size() - 1)].tag) : TAGW'($urandom);
         wb2_tag   = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                     TAGW'(q[$urandom_range(0, q.size() - 1)].tag) : TAGW'($urandom);
         recover   = ($urandom_range(0, 149) == 0);
         rst       = ($urandom_range(0, 499) == 0);
         applyStimulus();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
